// File: rtl/ex_stage.sv
// Execute stage: operand selection, ALU and a single registered output slot
// with a valid/ready handshake toward EX/MEM.
module ex_stage #(
  parameter int unsigned NB_DATA       = 32,
  parameter int unsigned NB_ADDR       = 5,
  parameter int unsigned NB_ALU_OPCODE = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NB_ALU_OPCODE-1:0] i_alu_opcode,
  input  logic                     i_second_ope_sa,
  input  logic                     i_first_ope_rt,
  input  logic [NB_DATA-1:0]       i_rs_data,
  input  logic [NB_DATA-1:0]       i_rt_data,
  input  logic [NB_DATA-1:0]       i_imm,
  input  logic                     i_use_imm,
  input  logic [NB_ADDR-1:0]       i_shamt,
  input  logic [NB_ADDR-1:0]       i_rd_addr,
  input  logic                     i_flush,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [NB_DATA-1:0]       o_result,
  output logic                     o_zero,
  output logic                     o_overflow,
  output logic [NB_ADDR-1:0]       o_rd_addr
);

  localparam logic [NB_ALU_OPCODE-1:0] OpSll  = NB_ALU_OPCODE'(4'b0000);
  localparam logic [NB_ALU_OPCODE-1:0] OpSrl  = NB_ALU_OPCODE'(4'b0010);
  localparam logic [NB_ALU_OPCODE-1:0] OpSra  = NB_ALU_OPCODE'(4'b0011);
  localparam logic [NB_ALU_OPCODE-1:0] OpSllv = NB_ALU_OPCODE'(4'b1010);
  localparam logic [NB_ALU_OPCODE-1:0] OpSrlv = NB_ALU_OPCODE'(4'b0110);
  localparam logic [NB_ALU_OPCODE-1:0] OpSrav = NB_ALU_OPCODE'(4'b0001);
  localparam logic [NB_ALU_OPCODE-1:0] OpAdd  = NB_ALU_OPCODE'(4'b1100);
  localparam logic [NB_ALU_OPCODE-1:0] OpSub  = NB_ALU_OPCODE'(4'b1011);
  localparam logic [NB_ALU_OPCODE-1:0] OpAnd  = NB_ALU_OPCODE'(4'b0100);
  localparam logic [NB_ALU_OPCODE-1:0] OpOr   = NB_ALU_OPCODE'(4'b1101);
  localparam logic [NB_ALU_OPCODE-1:0] OpXor  = NB_ALU_OPCODE'(4'b1110);
  localparam logic [NB_ALU_OPCODE-1:0] OpNor  = NB_ALU_OPCODE'(4'b0111);
  localparam logic [NB_ALU_OPCODE-1:0] OpSlt  = NB_ALU_OPCODE'(4'b1001);
  localparam logic [NB_ALU_OPCODE-1:0] OpLui  = NB_ALU_OPCODE'(4'b1111);
  localparam int unsigned Msb    = NB_DATA - 1;
  localparam int unsigned LuiPad = NB_DATA - 16;

  logic [NB_DATA-1:0] w_a;
  logic [NB_DATA-1:0] w_b;
  logic [NB_ADDR-1:0] w_sh;
  logic [NB_DATA-1:0] w_sum;
  logic [NB_DATA-1:0] w_diff;
  logic [NB_DATA-1:0] w_res;
  logic               w_ovf;
  logic               w_xfer;

  logic               r_valid;
  logic [NB_DATA-1:0] r_result;
  logic               r_zero;
  logic               r_overflow;
  logic [NB_ADDR-1:0] r_rd_addr;

  // Shifts take their data from rt; variable shifts take the amount from rs.
  always_comb begin
    w_a = (i_first_ope_rt || i_second_ope_sa) ? i_rt_data : i_rs_data;
    if (i_second_ope_sa)     w_b = {{(NB_DATA-NB_ADDR){1'b0}}, i_shamt};
    else if (i_first_ope_rt) w_b = i_rs_data;
    else if (i_use_imm)      w_b = i_imm;
    else                     w_b = i_rt_data;
  end

  assign w_sh   = w_b[NB_ADDR-1:0];
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (i_alu_opcode)
      OpSll, OpSllv: w_res = w_a << w_sh;
      OpSrl, OpSrlv: w_res = w_a >> w_sh;
      OpSra, OpSrav: w_res = $signed(w_a) >>> w_sh;
      OpAdd: begin
        w_res = w_sum;
        w_ovf = (w_a[Msb] == w_b[Msb]) && (w_sum[Msb] != w_a[Msb]);
      end
      OpSub: begin
        w_res = w_diff;
        w_ovf = (w_a[Msb] != w_b[Msb]) && (w_diff[Msb] != w_a[Msb]);
      end
      OpAnd: w_res = w_a & w_b;
      OpOr:  w_res = w_a | w_b;
      OpXor: w_res = w_a ^ w_b;
      OpNor: w_res = ~(w_a | w_b);
      OpSlt: w_res = {{(NB_DATA-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OpLui: w_res = {w_b[15:0], {LuiPad{1'b0}}};
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Flush never gates o_ready; it only suppresses the transfer.
  assign o_ready = !r_valid || i_ready;
  assign w_xfer  = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      if (i_flush)      r_valid <= 1'b0;
      else if (w_xfer)  r_valid <= 1'b1;
      else if (i_ready) r_valid <= 1'b0;
      if (w_xfer) begin
        r_result   <= w_res;
        r_zero     <= (w_res == '0);
        r_overflow <= w_ovf;
        r_rd_addr  <= i_rd_addr;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_overflow = r_overflow;
  assign o_rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU results, handshake stalls, flush and reset.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_alu_opcode;
  logic        i_second_ope_sa;
  logic        i_first_ope_rt;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [31:0] i_imm;
  logic        i_use_imm;
  logic [4:0]  i_shamt;
  logic [4:0]  i_rd_addr;
  logic        i_flush;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_overflow;
  logic [4:0]  o_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(
    .NB_DATA      (32),
    .NB_ADDR      (5),
    .NB_ALU_OPCODE(4)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_alu_opcode   (i_alu_opcode),
    .i_second_ope_sa(i_second_ope_sa),
    .i_first_ope_rt (i_first_ope_rt),
    .i_rs_data      (i_rs_data),
    .i_rt_data      (i_rt_data),
    .i_imm          (i_imm),
    .i_use_imm      (i_use_imm),
    .i_shamt        (i_shamt),
    .i_rd_addr      (i_rd_addr),
    .i_flush        (i_flush),
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_result       (o_result),
    .o_zero         (o_zero),
    .o_overflow     (o_overflow),
    .o_rd_addr      (o_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation; caller chooses i_ready/i_flush.
  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic sa, input logic frt,
                       input logic uimm, input logic [4:0] shamt, input logic [4:0] rd);
    i_valid         = 1'b1;
    i_alu_opcode    = op;
    i_rs_data       = rs;
    i_rt_data       = rt;
    i_imm           = imm;
    i_second_ope_sa = sa;
    i_first_ope_rt  = frt;
    i_use_imm       = uimm;
    i_shamt         = shamt;
    i_rd_addr       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    drive(4'b1100, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    i_valid = 1'b0;
    step(); step();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_tests++; if ({o_result, o_zero, o_overflow, o_rd_addr} !== 39'd0) begin n_fail++;
      $display("FAIL reset_data: got %h/%b/%b/%h expected 0", o_result, o_zero, o_overflow,
               o_rd_addr); end
  endtask

  // Also the first transfer after reset release.
  task automatic test_add();
    rst_n = 1'b1;
    drive(4'b1100, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++;
      $display("FAIL add_valid: got %b expected 1", o_valid); end
    n_tests++; if (o_result !== 32'h8000_0000) begin n_fail++;
      $display("FAIL add_result: got %h expected 80000000", o_result); end
    n_tests++; if (o_overflow !== 1'b1 || o_zero !== 1'b0) begin n_fail++;
      $display("FAIL add_flags: got ovf=%b zero=%b expected ovf=1 zero=0", o_overflow, o_zero); end
    n_tests++; if (o_rd_addr !== 5'd3) begin n_fail++;
      $display("FAIL add_rd: got %0d expected 3", o_rd_addr); end
    step();
    n_tests++; if (o_valid !== 1'b0 || o_result !== 32'h8000_0000) begin n_fail++;
      $display("FAIL add_drain: got valid=%b res=%h expected 0/80000000", o_valid, o_result); end
  endtask

  task automatic test_sub();
    drive(4'b1011, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4);
    step();
    n_tests++; if (o_result !== 32'h0 || o_zero !== 1'b1 || o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero: got res=%h zero=%b ovf=%b expected 0/1/0", o_result,
                         o_zero, o_overflow); end
    drive(4'b1011, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_result !== 32'h7FFF_FFFF || o_overflow !== 1'b1) begin n_fail++;
      $display("FAIL sub_ovf: got res=%h ovf=%b expected 7fffffff/1", o_result, o_overflow); end
    step();
  endtask

  task automatic test_shift();
    drive(4'b0011, 32'hDEAD_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd6);
    step();
    n_tests++; if (o_result !== 32'hF800_0000) begin n_fail++;
      $display("FAIL sra_result: got %h expected f8000000", o_result); end
    drive(4'b1010, 32'h25, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd7);
    step();
    n_tests++; if (o_result !== 32'h20) begin n_fail++;
      $display("FAIL sllv_result: got %h expected 00000020", o_result); end
    drive(4'b0010, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd8);
    step();
    n_tests++; if (o_result !== 32'h0800_0000) begin n_fail++;
      $display("FAIL srl_result: got %h expected 08000000", o_result); end
    drive(4'b0001, 32'h24, 32'hF000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd9);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_result !== 32'hFF00_0000) begin n_fail++;
      $display("FAIL srav_result: got %h expected ff000000", o_result); end
    step();
  endtask

  task automatic test_slt_lui();
    drive(4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd10);
    step();
    n_tests++; if (o_result !== 32'h1) begin n_fail++;
      $display("FAIL slt_result: got %h expected 00000001", o_result); end
    drive(4'b1111, 32'h0, 32'h0, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1, 5'd0, 5'd11);
    step();
    n_tests++; if (o_result !== 32'hABCD_0000) begin n_fail++;
      $display("FAIL lui_result: got %h expected abcd0000", o_result); end
    drive(4'b1000, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_result !== 32'h0 || o_zero !== 1'b1 || o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL unlisted_op: got res=%h zero=%b ovf=%b expected 0/1/0", o_result,
                         o_zero, o_overflow); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(4'b0100, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
    step();
    i_ready = 1'b0;
    drive(4'b1101, 32'h1200_0000, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'h00F0_0F00 ||
          o_rd_addr !== 5'd13) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b rdy=%b res=%h rd=%0d expected 1/0/00f00f00/13",
                           c, o_valid, o_ready, o_result, o_rd_addr); end
    end
    i_ready = 1'b1;
    #1;
    n_tests++; if (o_ready !== 1'b1) begin n_fail++;
      $display("FAIL stall_release_ready: got %b expected 1", o_ready); end
    step();
    n_tests++; if (o_valid !== 1'b1 || o_result !== 32'h1200_0034 || o_rd_addr !== 5'd14) begin
      n_fail++; $display("FAIL b2b_or: got v=%b res=%h rd=%0d expected 1/12000034/14", o_valid,
                         o_result, o_rd_addr); end
    drive(4'b1110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd15);
    step();
    n_tests++; if (o_valid !== 1'b1 || o_result !== 32'hF0F0_0F0F || o_rd_addr !== 5'd15) begin
      n_fail++; $display("FAIL b2b_xor: got v=%b res=%h rd=%0d expected 1/f0f00f0f/15", o_valid,
                         o_result, o_rd_addr); end
    drive(4'b0111, 32'h0000_FFFF, 32'h00FF_0000, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd16);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b1 || o_result !== 32'hFF00_0000 || o_rd_addr !== 5'd16) begin
      n_fail++; $display("FAIL b2b_nor: got v=%b res=%h rd=%0d expected 1/ff000000/16", o_valid,
                         o_result, o_rd_addr); end
    step();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_flush();
    drive(4'b1100, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd17);
    step();
    n_tests++; if (o_valid !== 1'b1 || o_result !== 32'h5) begin n_fail++;
      $display("FAIL flush_setup: got v=%b res=%h expected 1/00000005", o_valid, o_result); end
    // Flush while stalled: valid drops, data held.
    i_ready = 1'b0; i_flush = 1'b1; i_valid = 1'b0;
    step();
    n_tests++; if (o_valid !== 1'b0 || o_result !== 32'h5) begin n_fail++;
      $display("FAIL flush_stalled: got v=%b res=%h expected 0/00000005", o_valid, o_result); end
    // Refill, then flush with a same-cycle offer that must be blocked.
    i_flush = 1'b0; i_ready = 1'b1;
    drive(4'b1100, 32'h10, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd18);
    step();
    drive(4'b1100, 32'h20, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd19);
    i_flush = 1'b1;
    #1;
    n_tests++; if (o_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_ready: got %b expected 1", o_ready); end
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b0 || o_result !== 32'h11 || o_rd_addr !== 5'd18) begin
      n_fail++; $display("FAIL flush_block: got v=%b res=%h rd=%0d expected 0/00000011/18",
                         o_valid, o_result, o_rd_addr); end
  endtask

  task automatic test_reset_midstall();
    drive(4'b1101, 32'h5, 32'hA, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd20);
    step();
    i_ready = 1'b0; i_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++;
      $display("FAIL midstall_rst_ctrl: got v=%b rdy=%b expected 0/1", o_valid, o_ready); end
    n_tests++; if ({o_result, o_zero, o_overflow, o_rd_addr} !== 39'd0) begin n_fail++;
      $display("FAIL midstall_rst_data: got %h/%b/%b/%h expected 0", o_result, o_zero,
               o_overflow, o_rd_addr); end
    step();
    rst_n = 1'b1; i_ready = 1'b1;
    drive(4'b1100, 32'h40, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd21);
    step();
    i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b1 || o_result !== 32'h42 || o_rd_addr !== 5'd21) begin
      n_fail++; $display("FAIL post_rst_xfer: got v=%b res=%h rd=%0d expected 1/00000042/21",
                         o_valid, o_result, o_rd_addr); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_slt_lui();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, meaning datapath width.
REQ-002 The module SHALL have parameter NB_ADDR, default 5, meaning register-address and shift-amount width.
REQ-003 The module SHALL have parameter NB_ALU_OPCODE, default 4, meaning ALU opcode width.
REQ-004 The module SHALL have port i_clock, input, 1, meaning the single clock; all state SHALL be updated on its rising edge.
REQ-005 The module SHALL have port i_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The module SHALL have port i_valid, input, 1, meaning an upstream operation is offered.
REQ-007 The module SHALL have port o_ready, output, 1, meaning the block accepts an offer this cycle.
REQ-008 The module SHALL have port i_alu_opcode, input, NB_ALU_OPCODE, meaning the opcode from the ALU control stage.
REQ-009 The module SHALL have port i_second_ope_sa, input, 1, meaning the second operand is the shift amount.
REQ-010 The module SHALL have port i_first_ope_rt, input, 1, meaning the first operand is rt (variable shift).
REQ-011 The module SHALL have ports i_rs_data and i_rt_data, input, NB_DATA each, meaning the register-file operands.
REQ-012 The module SHALL have port i_imm, input, NB_DATA, meaning the pre-extended immediate.
REQ-013 The module SHALL have port i_use_imm, input, 1, meaning the immediate replaces rt as the second operand.
REQ-014 The module SHALL have port i_shamt, input, NB_ADDR, meaning the instruction sa field.
REQ-015 The module SHALL have port i_rd_addr, input, NB_ADDR, meaning the destination register (passed through).
REQ-016 The module SHALL have port i_flush, input, 1, meaning kill the held result.
REQ-017 The module SHALL have port i_ready, input, 1, meaning downstream (EX/MEM) accepts.
REQ-018 The module SHALL have ports o_valid (1), o_result (NB_DATA), o_zero (1), o_overflow (1) and o_rd_addr (NB_ADDR), all outputs and all registered.

Function
REQ-019 Handshake: o_ready SHALL equal (!o_valid || i_ready), and a transfer SHALL occur when i_valid && o_ready.
REQ-020 On a transfer, the result of the offered operation SHALL be registered and o_valid SHALL be 1 on the next cycle, giving 1-cycle latency.
REQ-021 When o_valid && !i_ready, every output SHALL hold its value unchanged.
REQ-022 When o_valid && i_ready && no new transfer occurs, o_valid SHALL drop to 0.
REQ-023 Operand A SHALL be rt when (i_first_ope_rt || i_second_ope_sa), and rs otherwise.
REQ-024 Operand B SHALL be the zero-extended i_shamt when i_second_ope_sa is set, otherwise rs when i_first_ope_rt is set, otherwise i_imm when i_use_imm is set, otherwise rt.
REQ-025 Opcode map: 0000 SLL, 0010 SRL, 0011 SRA, 1010 SLLV, 0110 SRLV, 0001 SRAV; each SHALL shift A by B[NB_ADDR-1:0], with SRA/SRAV arithmetic.
REQ-026 Opcode map: 1100 ADD = A+B, 1011 SUB = A-B, 0100 AND, 1101 OR, 1110 XOR, 0111 NOR, each modulo 2^NB_DATA.
REQ-027 Opcode map: 1001 SLT SHALL return 1 if A<B as signed values, else 0.
REQ-028 Opcode map: 1111 LUI SHALL return {B[15:0], 16'b0}.
REQ-029 Any unlisted opcode SHALL produce a result of 0 with o_overflow 0.
REQ-030 o_zero SHALL be 1 exactly when the registered result equals 0.
REQ-031 o_overflow SHALL be the signed overflow of ADD/SUB only, and 0 for all other opcodes.
REQ-032 o_rd_addr SHALL register i_rd_addr on each transfer.
REQ-033 i_flush SHALL clear o_valid next cycle regardless of i_ready and SHALL block any same-cycle transfer; o_ready SHALL be unaffected by i_flush.
REQ-034 Data outputs SHALL be registered only on a transfer; when no transfer occurs they retain their values.

Reset
REQ-035 While i_reset_n is 0, o_valid, o_result, o_zero, o_overflow and o_rd_addr SHALL be 0 asynchronously, so o_ready = 1.
REQ-036 An operation in flight at reset assertion SHALL be discarded, and the first transfer SHALL be accepted on the first rising edge with i_reset_n = 1.

Verification
REQ-037 The bench SHALL apply ADD with rs=0x7FFFFFFF and rt=1 and SHALL check o_result=0x80000000, o_overflow=1, o_zero=0 one cycle later.
REQ-038 The bench SHALL apply SUB with rs=rt=0x1234 and SHALL check o_result=0 and o_zero=1.
REQ-039 The bench SHALL apply SRA with i_second_ope_sa=1, rt=0x80000000 and shamt=4, and SHALL check o_result=0xF8000000; it SHALL then apply SLLV with i_first_ope_rt=1, rt=1 and rs=0x25, and SHALL check o_result=0x20.
REQ-040 The bench SHALL apply SLT with rs=0xFFFFFFFF and rt=1 and SHALL check o_result=1, then apply LUI with i_use_imm=1 and imm=0xABCD and SHALL check o_result=0xABCD0000.
REQ-041 The bench SHALL hold i_ready=0 for 3 cycles with o_valid=1 and SHALL check that the outputs are stable and o_ready=0; it SHALL then raise i_ready with i_valid=1 and check back-to-back transfers.
REQ-042 The bench SHALL assert i_flush while o_valid=1 and SHALL check o_valid=0 next cycle; it SHALL then assert i_reset_n=0 mid-stall and check all outputs are 0 immediately.
